multiexp_feeder: RTL and testbench
==================================

MULTIEXP_FEEDER -- requirements
Module: multiexp_feeder

Interface
REQ-001 Parameter DAT_BITS, default $bits(fe_t) (256), scalar width; also the number of replay passes.
REQ-002 Parameter DAT_BYTS, default ($bits(fe_t)+$bits(jb_point_t)+7)/8, stream width in bytes of one {point, scalar} word.
REQ-003 Parameter NUM_MAX, default 1024, maximum stored pairs; RAM depth.
REQ-004 Parameter CTL_BITS, default 8, stream ctl width.
REQ-005 i_clk  input  1  single clock; all logic on rising edge.
REQ-006 i_rst  input  1  reset, synchronous, active-low.
REQ-007 i_num_in  input  64  pair count; sampled on the first accepted load word.
REQ-008 i_pnt_scl_if  slave if_axi_stream (DAT_BYTS, CTL_BITS)  load stream, one {jb_point_t, fe_t} per word.
REQ-009 o_pnt_scl_if  master if_axi_stream (DAT_BYTS, CTL_BITS)  replay stream toward multiexp_top.i_pnt_scl_if.
REQ-010 o_busy  output  1  high in LOAD or REPLAY.
REQ-011 o_err  output  1  sticky: i_num_in was 0 or >NUM_MAX; cleared by reset or the next accepted load word.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, REPLAY, FLUSH.
REQ-013 In IDLE, i_pnt_scl_if.rdy SHALL be 1; the first accepted word latches N=i_num_in and is written at address 0.
REQ-014 If N==0 or N>NUM_MAX, the word SHALL be dropped, o_err set, and the FSM SHALL stay in IDLE.
REQ-015 After a valid first word: N==1 -> REPLAY; else -> LOAD.
REQ-016 In LOAD, each accepted word SHALL be written at incrementing address; after the N-th word the FSM SHALL go to REPLAY and rdy SHALL drop the same cycle.
REQ-017 Load stream sop/eop/ctl SHALL be ignored; only the word count delimits a batch.
REQ-018 In REPLAY, the block SHALL emit DAT_BITS passes; each pass emits RAM addresses 0..N-1 in order, for N*DAT_BITS output words.
REQ-019 Output ctl SHALL equal the bit index of the pass, DAT_BITS-1 down to 0 (MSB first), truncated to CTL_BITS.
REQ-020 Output sop SHALL be 1 only on word 0 of pass 0; eop SHALL be 1 only on word N-1 of the last pass; mod SHALL be 0; err SHALL be 0.
REQ-021 RAM read latency SHALL be 1 cycle; a 2-entry skid buffer SHALL hold reads so o_pnt_scl_if.rdy backpressure never drops or duplicates a word.
REQ-022 Output val SHALL not depend combinationally on o_pnt_scl_if.rdy, and dat/ctl SHALL be stable while val=1 and rdy=0.
REQ-023 With rdy held 1, the first output word SHALL be valid 2 cycles after the last load word is accepted, with one word per cycle thereafter and no gap at pass boundaries.
REQ-024 The address counter SHALL wrap N-1 -> 0 and decrement the pass counter in the same cycle; the pass counter at 0 plus the wrap SHALL end reads.
REQ-025 FLUSH SHALL drain the skid buffer; when the eop word is accepted the FSM SHALL return to IDLE, and a new load word SHALL be accepted the following cycle.
REQ-026 While in LOAD, REPLAY or FLUSH, i_num_in changes SHALL be ignored.
REQ-027 In REPLAY and FLUSH, i_pnt_scl_if.rdy SHALL be 0.

Reset
REQ-028 Reset SHALL force: state IDLE, counters 0, skid empty, o_pnt_scl_if.val=0, sop/eop=0, ctl=0, i_pnt_scl_if.rdy=0 during reset and 1 the cycle after release, o_busy=0, o_err=0.
REQ-029 Reset asserted mid-LOAD or mid-REPLAY SHALL abandon the batch; RAM contents need not be cleared, and no further output words SHALL appear.

Structure
REQ-030 jb_point_t and fe_t SHALL come from bn128_pkg; the state enum SHALL be local to the module; no new package constants are required.
REQ-031 Storage SHALL be one sub-module, bram_sdp (simple dual-port, 1-cycle read, parameterised width/depth); the FSM, counters and skid buffer SHALL stay in multiexp_feeder.

Verification
REQ-032 N=4, DAT_BITS=256, rdy=1 -> 1024 words; word k = stored pair k%4; ctl = 255-k/4 (mod 256); sop at word 0; eop at word 1023; no idle cycles after the first word.
REQ-033 N=4 with rdy toggling at random 50% -> identical 1024-word sequence; val never drops while rdy=0.
REQ-034 i_num_in=0, then NUM_MAX+1 -> o_err=1, no output, rdy stays 1; a following valid N=1 batch -> 256 words, sop=eop pattern correct, o_err cleared.
REQ-035 Reset asserted after 100 replay words -> val=0 the next cycle; after release a new N=2 batch replays correctly (512 words).
REQ-036 Back-to-back batches N=3 then N=5 -> second load accepted the cycle after the first eop; outputs match each batch.
REQ-037 End-to-end: feeder driving multiexp_top (NUM_CORES=2, N=4) loaded once -> result equals multiexp_parallel_batch in affine form.

Source files
------------

// File: rtl/bn128_pkg.sv
// Field-element and Jacobian-point types shared by the multi-exponentiation blocks.
package bn128_pkg;

   typedef logic [255:0] fe_t;

   typedef struct packed {
      fe_t x;
      fe_t y;
      fe_t z;
   } jb_point_t;

endpackage

// File: rtl/if_axi_stream.sv
// Valid/ready word stream with start/end markers, byte-count and sideband ctl.
interface if_axi_stream #(
   parameter int DAT_BYTS = 128,
   parameter int CTL_BITS = 8
);
   localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

   logic                  val;
   logic                  rdy;
   logic                  sop;
   logic                  eop;
   logic                  err;
   logic [MOD_BITS-1:0]   mod;
   logic [CTL_BITS-1:0]   ctl;
   logic [DAT_BYTS*8-1:0] dat;

   modport master (output val, sop, eop, err, mod, ctl, dat, input rdy);
   modport slave  (input val, sop, eop, err, mod, ctl, dat, output rdy);

endinterface

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module bram_sdp #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 1024,
   parameter int ADDR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic                 re,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [WIDTH-1:0]     rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the array has no reset so it maps onto block RAM; non-blocking
   // assignments keep read-before-write ordering identical in sim and silicon.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/multiexp_feeder.sv
// Buffers one batch of {point, scalar} words, then replays it once per scalar bit,
// MSB first, through a 2-entry skid buffer toward the multi-exponentiation core.
module multiexp_feeder
   import bn128_pkg::*;
#(
   parameter int DAT_BITS = $bits(fe_t),
   parameter int DAT_BYTS = ($bits(fe_t) + $bits(jb_point_t) + 7) / 8,
   parameter int NUM_MAX  = 1024,
   parameter int CTL_BITS = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [63:0]  i_num_in,
   if_axi_stream.slave  i_pnt_scl_if,
   if_axi_stream.master o_pnt_scl_if,
   output logic         o_busy,
   output logic         o_err
);

   localparam int DW = DAT_BYTS * 8;
   localparam int AW = (NUM_MAX > 1) ? $clog2(NUM_MAX) : 1;
   localparam int NW = $clog2(NUM_MAX + 1);
   localparam int PW = (DAT_BITS > 1) ? $clog2(DAT_BITS) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, REPLAY, FLUSH} state_t;

   typedef struct packed {
      logic [CTL_BITS-1:0] ctl;
      logic                sop;
      logic                eop;
   } meta_t;

   state_t        state;
   logic [NW-1:0] num;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic [PW-1:0] pass;
   logic          in_rdy;
   logic          err;

   logic          rd_pend;
   meta_t         pend_meta;
   logic [1:0]    sk_cnt;
   meta_t         sk_meta [2];
   logic [DW-1:0] sk_dat  [2];
   logic [DW-1:0] ram_q;

   logic          acc_in, num_bad, ram_we, rd_en, pop, out_val;
   logic          last_wr, last_rd, wr0_new, wr0_shift, wr1_new;
   logic [AW-1:0] ram_waddr;
   logic [1:0]    occ;
   logic          load_unused;

   // NOTE: every always_comb output is assigned on every path, so no latches.
   always_comb begin
      acc_in    = in_rdy && i_pnt_scl_if.val;
      num_bad   = (i_num_in == 64'd0) || (i_num_in > 64'(NUM_MAX));
      ram_we    = acc_in && ((state == LOAD) || ((state == IDLE) && !num_bad));
      ram_waddr = (state == IDLE) ? '0 : wr_addr;
      last_wr   = (NW'(wr_addr) == num - NW'(1));
      last_rd   = (NW'(rd_addr) == num - NW'(1));
      out_val   = (sk_cnt != 2'd0);
      pop       = out_val && o_pnt_scl_if.rdy;
      // Reads in flight plus held words never exceed the two skid slots.
      occ       = sk_cnt + 2'(rd_pend);
      rd_en     = (state == REPLAY) && ((occ < 2'd2) || ((occ == 2'd2) && pop));
      wr0_new   = rd_pend && ((sk_cnt == 2'd0) || (pop && (sk_cnt == 2'd1)));
      wr0_shift = pop && (sk_cnt == 2'd2);
      wr1_new   = rd_pend && (((sk_cnt == 2'd1) && !pop) || ((sk_cnt == 2'd2) && pop));
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state   <= IDLE;
         num     <= '0;
         wr_addr <= '0;
         rd_addr <= '0;
         pass    <= '0;
         in_rdy  <= 1'b0;
         err     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               in_rdy <= 1'b1;
               if (acc_in) begin
                  err <= num_bad;
                  if (!num_bad) begin
                     num     <= NW'(i_num_in);
                     wr_addr <= AW'(1);
                     rd_addr <= '0;
                     pass    <= PW'(DAT_BITS - 1);
                     if (i_num_in == 64'd1) begin
                        state  <= REPLAY;
                        in_rdy <= 1'b0;
                     end else begin
                        state <= LOAD;
                     end
                  end
               end
            end
            LOAD: begin
               if (acc_in) begin
                  if (last_wr) begin
                     state  <= REPLAY;
                     in_rdy <= 1'b0;
                  end else begin
                     wr_addr <= wr_addr + AW'(1);
                  end
               end
            end
            REPLAY: begin
               if (rd_en) begin
                  if (last_rd) begin
                     rd_addr <= '0;
                     if (pass == '0) state <= FLUSH;
                     else            pass  <= pass - PW'(1);
                  end else begin
                     rd_addr <= rd_addr + AW'(1);
                  end
               end
            end
            FLUSH: begin
               if (pop && sk_meta[0].eop) begin
                  state  <= IDLE;
                  in_rdy <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         rd_pend    <= 1'b0;
         pend_meta  <= '0;
         sk_cnt     <= '0;
         sk_meta[0] <= '0;
         sk_meta[1] <= '0;
      end else begin
         rd_pend <= rd_en;
         if (rd_en) begin
            pend_meta <= '{ctl: CTL_BITS'(pass),
                           sop: (rd_addr == '0) && (pass == PW'(DAT_BITS - 1)),
                           eop: last_rd && (pass == '0)};
         end
         sk_cnt <= sk_cnt + 2'(rd_pend) - 2'(pop);
         if (wr0_new)        sk_meta[0] <= pend_meta;
         else if (wr0_shift) sk_meta[0] <= sk_meta[1];
         if (wr1_new)        sk_meta[1] <= pend_meta;
      end
   end

   // Payload slots carry no reset; sk_cnt alone decides whether they are valid.
   always_ff @(posedge i_clk) begin
      if (wr0_new)        sk_dat[0] <= ram_q;
      else if (wr0_shift) sk_dat[0] <= sk_dat[1];
      if (wr1_new)        sk_dat[1] <= ram_q;
   end

   bram_sdp #(
      .WIDTH     (DW),
      .DEPTH     (NUM_MAX),
      .ADDR_BITS (AW)
   ) u_ram (
      .clk   (i_clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (i_pnt_scl_if.dat),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (ram_q)
   );

   assign i_pnt_scl_if.rdy = in_rdy;
   assign o_pnt_scl_if.val = out_val;
   assign o_pnt_scl_if.dat = sk_dat[0];
   assign o_pnt_scl_if.ctl = sk_meta[0].ctl;
   assign o_pnt_scl_if.sop = out_val && sk_meta[0].sop;
   assign o_pnt_scl_if.eop = out_val && sk_meta[0].eop;
   assign o_pnt_scl_if.mod = '0;
   assign o_pnt_scl_if.err = 1'b0;
   assign o_busy           = (state == LOAD) || (state == REPLAY);
   assign o_err            = err;

   // Load-side framing is deliberately ignored; the word count delimits a batch.
   assign load_unused = ^{i_pnt_scl_if.sop, i_pnt_scl_if.eop, i_pnt_scl_if.err,
                          i_pnt_scl_if.mod, i_pnt_scl_if.ctl};

endmodule

// File: tb/tb_multiexp_feeder.sv
// Self-checking bench for multiexp_feeder: expected replay streams are derived from
// the stored batch (word k = pair k mod N, ctl = top bit index minus k div N).
module tb_multiexp_feeder;
   import bn128_pkg::*;

   localparam int DAT_BITS = $bits(fe_t);
   localparam int DAT_BYTS = ($bits(fe_t) + $bits(jb_point_t) + 7) / 8;
   localparam int NUM_MAX  = 1024;
   localparam int CTL_BITS = 8;
   localparam int DW       = DAT_BYTS * 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] num_in = '0;
   logic        busy;
   logic        err;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   logic [DW-1:0] pairs [4][8];
   int            nb [4];
   int            load_first_cyc [4];
   int            load_done_cyc [4];
   int            eop_cyc [4];

   typedef struct {
      logic [63:0] num;
      logic        exp_err;
      logic        exp_rdy;
      logic        exp_busy;
      logic        exp_val;
   } err_vec_t;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   if_axi_stream #(.DAT_BYTS(DAT_BYTS), .CTL_BITS(CTL_BITS)) in_if ();
   if_axi_stream #(.DAT_BYTS(DAT_BYTS), .CTL_BITS(CTL_BITS)) out_if ();

   multiexp_feeder #(
      .DAT_BITS (DAT_BITS),
      .DAT_BYTS (DAT_BYTS),
      .NUM_MAX  (NUM_MAX),
      .CTL_BITS (CTL_BITS)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_num_in     (num_in),
      .i_pnt_scl_if (in_if),
      .o_pnt_scl_if (out_if),
      .o_busy       (busy),
      .o_err        (err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int j = 0; j < DW / 32; j++) w[j*32 +: 32] = $urandom;
      return w;
   endfunction

   task automatic fill(input int b, input int n);
      nb[b] = n;
      for (int i = 0; i < n; i++) pairs[b][i] = rand_word();
   endtask

   // Presents the batch words back to back; framing and later i_num_in are junk.
   task automatic load(input int b, input bit release_bus);
      int i = 0;
      int budget = 20000;
      while (i < nb[b] && budget > 0) begin
         @(negedge clk);
         budget--;
         in_if.val = 1'b1;
         in_if.dat = pairs[b][i];
         in_if.sop = 1'($urandom);
         in_if.eop = 1'($urandom);
         in_if.err = 1'($urandom);
         in_if.ctl = CTL_BITS'($urandom);
         in_if.mod = '0;
         num_in    = (i == 0) ? 64'(nb[b]) : {$urandom, $urandom};
         if (in_if.rdy === 1'b1) begin
            if (i == 0)         load_first_cyc[b] = cyc + 1;
            if (i == nb[b] - 1) load_done_cyc[b]  = cyc + 1;
            i++;
         end
      end
      check($sformatf("load%0d_words", b), 64'(i), 64'(nb[b]));
      if (release_bus) begin
         @(negedge clk);
         in_if.val = 1'b0;
      end
   endtask

   task automatic collect(input int b, input bit toggle, input int stop_after,
                          input bit watch, input string tag);
      int n = nb[b];
      int total = n * DAT_BITS;
      int lim = (stop_after > 0) ? stop_after : total;
      int k = 0;
      int budget = total * 4 + 200;
      int first = -1;
      int last = 0;
      int data_bad = 0, meta_bad = 0, hold_bad = 0, inrdy_bad = 0;
      bit stall = 1'b0;
      logic [DW-1:0]       held_dat;
      logic [CTL_BITS-1:0] held_ctl;
      logic [CTL_BITS-1:0] exp_ctl;
      while (k < lim && budget > 0) begin
         @(negedge clk);
         budget--;
         if (stall && (out_if.val !== 1'b1 || out_if.dat !== held_dat || out_if.ctl !== held_ctl))
            hold_bad++;
         out_if.rdy = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
         stall = 1'b0;
         if (out_if.val === 1'b1) begin
            if (first < 0) first = cyc;
            if (in_if.rdy !== 1'b0) inrdy_bad++;
            if (out_if.rdy) begin
               exp_ctl = CTL_BITS'(DAT_BITS - 1 - k / n);
               if (out_if.dat !== pairs[b][k % n]) data_bad++;
               if (out_if.ctl !== exp_ctl || out_if.sop !== (k == 0) ||
                   out_if.eop !== (k == total - 1) || out_if.mod !== '0 || out_if.err !== 1'b0)
                  meta_bad++;
               if (k == total - 1) eop_cyc[b] = cyc + 1;
               last = cyc;
               k++;
            end else begin
               stall    = 1'b1;
               held_dat = out_if.dat;
               held_ctl = out_if.ctl;
            end
         end else if (out_if.sop === 1'b1 || out_if.eop === 1'b1) begin
            meta_bad++;
         end
      end
      check({tag, "_words"}, 64'(k), 64'(lim));
      check({tag, "_data"}, 64'(data_bad), 64'd0);
      check({tag, "_ctl_sop_eop"}, 64'(meta_bad), 64'd0);
      check({tag, "_stall_hold"}, 64'(hold_bad), 64'd0);
      check({tag, "_load_rdy_low"}, 64'(inrdy_bad), 64'd0);
      check({tag, "_first_latency"}, 64'(first - load_done_cyc[b]), 64'd2);
      if (!toggle && stop_after == 0)
         check({tag, "_gapless"}, 64'(last - first), 64'(total - 1));
      if (watch) begin
         int extra = 0;
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_if.val !== 1'b0) extra++;
         end
         check({tag, "_no_extra_words"}, 64'(extra), 64'd0);
         check({tag, "_idle_busy"}, 64'(busy), 64'd0);
         check({tag, "_idle_load_rdy"}, 64'(in_if.rdy), 64'd1);
      end
   endtask

   initial begin
      err_vec_t vecs [3];
      int quiet;

      in_if.val  = 1'b0;
      in_if.dat  = '0;
      in_if.sop  = 1'b0;
      in_if.eop  = 1'b0;
      in_if.err  = 1'b0;
      in_if.ctl  = '0;
      in_if.mod  = '0;
      out_if.rdy = 1'b1;

      // Reset values, then rdy rises one cycle after release.
      repeat (3) @(negedge clk);
      check("rst_out_val", 64'(out_if.val), 64'd0);
      check("rst_out_sop_eop", 64'({out_if.sop, out_if.eop}), 64'd0);
      check("rst_out_ctl", 64'(out_if.ctl), 64'd0);
      check("rst_load_rdy", 64'(in_if.rdy), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      check("rel_load_rdy", 64'(in_if.rdy), 64'd1);

      // N=4, sink always ready.
      fill(0, 4);
      fork
         load(0, 1'b1);
         collect(0, 1'b0, 0, 1'b1, "n4_rdy");
      join

      // Same batch size with random backpressure.
      fill(0, 4);
      fork
         load(0, 1'b1);
         collect(0, 1'b1, 0, 1'b1, "n4_toggle");
      join
      out_if.rdy = 1'b1;

      // Illegal counts: dropped, error flagged, loader stays ready.
      vecs[0] = '{64'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{64'(NUM_MAX + 1), 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{64'h1_0000_0001, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int v = 0; v < 3; v++) begin
         int budget = 50;
         bit taken = 1'b0;
         while (!taken && budget > 0) begin
            @(negedge clk);
            budget--;
            in_if.val = 1'b1;
            in_if.dat = rand_word();
            num_in    = vecs[v].num;
            if (in_if.rdy === 1'b1) taken = 1'b1;
         end
         check($sformatf("bad%0d_taken", v), 64'(taken), 64'd1);
         @(negedge clk);
         in_if.val = 1'b0;
         check($sformatf("bad%0d_err", v), 64'(err), 64'(vecs[v].exp_err));
         check($sformatf("bad%0d_load_rdy", v), 64'(in_if.rdy), 64'(vecs[v].exp_rdy));
         check($sformatf("bad%0d_busy", v), 64'(busy), 64'(vecs[v].exp_busy));
         check($sformatf("bad%0d_out_val", v), 64'(out_if.val), 64'(vecs[v].exp_val));
      end

      // A legal N=1 batch afterwards replays and clears the error.
      fill(1, 1);
      fork
         load(1, 1'b1);
         collect(1, 1'b0, 0, 1'b1, "n1");
      join
      check("n1_err_cleared", 64'(err), 64'd0);

      // Reset in the middle of a replay abandons the batch.
      fill(0, 4);
      fork
         load(0, 1'b1);
         collect(0, 1'b1, 100, 1'b0, "mid");
      join
      @(negedge clk);
      rst = 1'b0;
      out_if.rdy = 1'b1;
      @(negedge clk);
      check("midrst_out_val", 64'(out_if.val), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_load_rdy", 64'(in_if.rdy), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      quiet = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_if.val !== 1'b0) quiet++;
      end
      check("midrst_no_output", 64'(quiet), 64'd0);
      check("midrst_rel_load_rdy", 64'(in_if.rdy), 64'd1);

      fill(1, 2);
      fork
         load(1, 1'b1);
         collect(1, 1'b0, 0, 1'b1, "n2_after_rst");
      join

      // Back-to-back batches: second load waits on the first eop.
      fill(2, 3);
      fill(3, 5);
      fork
         begin
            load(2, 1'b0);
            load(3, 1'b1);
         end
         begin
            collect(2, 1'b0, 0, 1'b0, "b2b_n3");
            collect(3, 1'b0, 0, 1'b1, "b2b_n5");
         end
      join
      check("b2b_accept_after_eop", 64'(load_first_cyc[3] - eop_cyc[2]), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
